// File: rtl/geo_pixel_pkg.sv
// rtl/geo_pixel_pkg.sv - command codes, FSM states, width codes and pixel_cmd field positions
package geo_pixel_pkg;

  typedef enum logic [3:0] {
    CMD_PXWRI         = 4'd1,
    CMD_PXWRI_M       = 4'd2,
    CMD_PXPASTE       = 4'd3,
    CMD_PXPASTE_M     = 4'd4,
    CMD_PXCOPY        = 4'd6,
    CMD_SETARGB       = 4'd7,
    CMD_RST_PXWRI_M   = 4'd10,
    CMD_RST_PXPASTE_M = 4'd11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } state_e;

  localparam logic [3:0] W_1BPP  = 4'd0;
  localparam logic [3:0] W_2BPP  = 4'd1;
  localparam logic [3:0] W_4BPP  = 4'd3;
  localparam logic [3:0] W_8BPP  = 4'd7;
  localparam logic [3:0] W_16BPP = 4'd15;

  localparam int CMD_HI  = 39;
  localparam int CMD_LO  = 36;
  localparam int COL_HI  = 35;
  localparam int COL_LO  = 28;
  localparam int WID_HI  = 27;
  localparam int WID_LO  = 24;
  localparam int TBIT_HI = 23;
  localparam int TBIT_LO = 20;
  localparam int ADDR_HI = 19;
  localparam int ADDR_LO = 0;

  function automatic logic width_legal(input logic [3:0] w);
    return (w == W_1BPP) || (w == W_2BPP) || (w == W_4BPP) ||
           (w == W_8BPP) || (w == W_16BPP);
  endfunction

endpackage

// File: rtl/geo_pixel_field.sv
// rtl/geo_pixel_field.sv - combinational pixel field insert/extract within a 16-bit word
module geo_pixel_field
  import geo_pixel_pkg::*;
(
  input  logic [15:0] i_word,
  input  logic [3:0]  i_width,
  input  logic [3:0]  i_tbit,
  input  logic [7:0]  i_colour,
  output logic [15:0] o_merged,
  output logic [7:0]  o_pixel,
  output logic        o_legal
);

  logic [3:0]  w_bit_pos;
  logic [15:0] w_lo_mask;
  logic [15:0] w_field_mask;
  logic [15:0] w_colour_sh;

  // Pixels are aligned to their own width, so low target bits inside the field are dropped.
  assign w_bit_pos    = i_tbit & ~i_width;
  assign w_lo_mask    = ~(16'hFFFE << i_width);
  assign w_field_mask = w_lo_mask << w_bit_pos;
  assign w_colour_sh  = ({8'h00, i_colour} & w_lo_mask) << w_bit_pos;

  assign o_merged = (i_word & ~w_field_mask) | w_colour_sh;
  assign o_pixel  = 8'((i_word >> w_bit_pos) & w_lo_mask);
  assign o_legal  = width_legal(i_width);

endmodule

// File: rtl/geo_pixel_writer.sv
// rtl/geo_pixel_writer.sv - pixel command to 16-bit read/modify/write memory transactions
// Optional collision counter on PXCOPY: GEO_PIXEL_WRITER_COLLISION_EN
module geo_pixel_writer
  import geo_pixel_pkg::*;
#(
  parameter int MEM_AW = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_cmd_rdy,
  input  logic [39:0]       pixel_cmd,
  output logic              draw_busy,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [15:0]       mem_wr_data,
  input  logic              mem_busy,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rd_data
`ifdef GEO_PIXEL_WRITER_COLLISION_EN
  ,
  output logic [15:0]       collision_count
`endif
);

  state_e            r_state;
  logic              r_busy;
  logic              r_rd_req;
  logic              r_wr_req;
  logic [MEM_AW-1:0] r_addr;
  logic [15:0]       r_wr_data;
  logic [3:0]        r_width;
  logic [3:0]        r_tbit;
  logic [7:0]        r_colour;
  logic              r_is_copy;
  logic [7:0]        r_copy_buf;
  logic [7:0]        r_wr_mask;
  logic [7:0]        r_paste_mask;
`ifdef GEO_PIXEL_WRITER_COLLISION_EN
  logic [7:0]        r_cmd_colour;
  logic [15:0]       r_coll_cnt;
`endif

  logic [3:0]  w_cmd;
  logic [7:0]  w_colour;
  logic [3:0]  w_width;
  logic [3:0]  w_tbit;
  logic [7:0]  w_wr_colour;
  logic        w_skip;
  logic [15:0] w_f_word;
  logic [3:0]  w_f_width;
  logic [3:0]  w_f_tbit;
  logic [7:0]  w_f_colour;
  logic [15:0] w_merged;
  logic [7:0]  w_pixel;
  logic        w_legal;

  assign w_cmd    = pixel_cmd[CMD_HI:CMD_LO];
  assign w_colour = pixel_cmd[COL_HI:COL_LO];
  assign w_width  = pixel_cmd[WID_HI:WID_LO];
  assign w_tbit   = pixel_cmd[TBIT_HI:TBIT_LO];

  assign w_wr_colour = ((w_cmd == CMD_PXPASTE) || (w_cmd == CMD_PXPASTE_M)) ? r_copy_buf : w_colour;
  assign w_skip = ((w_cmd == CMD_PXWRI_M)   && (w_colour == r_wr_mask)) ||
                  ((w_cmd == CMD_PXPASTE_M) && (r_copy_buf == r_paste_mask));

  // In IDLE the field unit sees the incoming command over a zero word, which yields the
  // full-word write value; in RD_WAIT it sees the latched command over the read data.
  assign w_f_word   = (r_state == ST_RD_WAIT) ? mem_rd_data : 16'h0000;
  assign w_f_width  = (r_state == ST_IDLE) ? w_width : r_width;
  assign w_f_tbit   = (r_state == ST_IDLE) ? w_tbit : r_tbit;
  assign w_f_colour = (r_state == ST_IDLE) ? w_wr_colour : r_colour;

  geo_pixel_field u_field (
    .i_word   (w_f_word),
    .i_width  (w_f_width),
    .i_tbit   (w_f_tbit),
    .i_colour (w_f_colour),
    .o_merged (w_merged),
    .o_pixel  (w_pixel),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_rd_req     <= 1'b0;
      r_wr_req     <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= 16'h0000;
      r_width      <= 4'h0;
      r_tbit       <= 4'h0;
      r_colour     <= 8'h00;
      r_is_copy    <= 1'b0;
      r_copy_buf   <= 8'h00;
      r_wr_mask    <= 8'h00;
      r_paste_mask <= 8'h00;
`ifdef GEO_PIXEL_WRITER_COLLISION_EN
      r_cmd_colour <= 8'h00;
      r_coll_cnt   <= 16'h0000;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (pixel_cmd_rdy) begin
            case (w_cmd)
              CMD_PXWRI, CMD_PXWRI_M, CMD_PXPASTE, CMD_PXPASTE_M: begin
                if (w_legal && !w_skip) begin
                  r_addr    <= MEM_AW'(pixel_cmd[ADDR_HI:ADDR_LO]) & ~(MEM_AW'(1));
                  r_width   <= w_width;
                  r_tbit    <= w_tbit;
                  r_colour  <= w_wr_colour;
                  r_is_copy <= 1'b0;
                  r_busy    <= 1'b1;
                  if (w_width == W_16BPP) begin
                    r_wr_data <= w_merged;
                    r_wr_req  <= 1'b1;
                    r_state   <= ST_WR_REQ;
                  end else begin
                    r_rd_req  <= 1'b1;
                    r_state   <= ST_RD_REQ;
                  end
                end
              end
              CMD_PXCOPY: begin
                if (w_legal) begin
                  r_addr    <= MEM_AW'(pixel_cmd[ADDR_HI:ADDR_LO]) & ~(MEM_AW'(1));
                  r_width   <= w_width;
                  r_tbit    <= w_tbit;
                  r_is_copy <= 1'b1;
                  r_busy    <= 1'b1;
                  r_rd_req  <= 1'b1;
                  r_state   <= ST_RD_REQ;
`ifdef GEO_PIXEL_WRITER_COLLISION_EN
                  r_cmd_colour <= w_colour;
`endif
                end
              end
              CMD_RST_PXWRI_M: r_wr_mask <= w_colour;
              CMD_RST_PXPASTE_M: begin
                r_paste_mask <= w_colour;
`ifdef GEO_PIXEL_WRITER_COLLISION_EN
                r_coll_cnt   <= 16'h0000;
`endif
              end
              default: ;
            endcase
          end
        end
        ST_RD_REQ: begin
          if (!mem_busy) begin
            r_rd_req <= 1'b0;
            r_state  <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (mem_rd_valid) begin
            if (r_is_copy) begin
              r_copy_buf <= w_pixel;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
`ifdef GEO_PIXEL_WRITER_COLLISION_EN
              if ((w_pixel != r_cmd_colour) && (r_coll_cnt != 16'hFFFF))
                r_coll_cnt <= r_coll_cnt + 16'h0001;
`endif
            end else begin
              r_wr_data <= w_merged;
              r_wr_req  <= 1'b1;
              r_state   <= ST_WR_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (!mem_busy) begin
            r_wr_req <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign draw_busy   = r_busy;
  assign mem_addr    = r_addr;
  assign mem_rd_req  = r_rd_req;
  assign mem_wr_req  = r_wr_req;
  assign mem_wr_data = r_wr_data;
`ifdef GEO_PIXEL_WRITER_COLLISION_EN
  assign collision_count = r_coll_cnt;
`endif

endmodule

// File: tb/tb_geo_pixel_writer.sv
// tb/tb_geo_pixel_writer.sv - scoreboard bench for geo_pixel_writer
// Collision checks enabled with GEO_PIXEL_WRITER_COLLISION_EN
module tb_geo_pixel_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_cmd_rdy;
  logic [39:0] pixel_cmd;
  logic        draw_busy;
  logic [19:0] mem_addr;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [15:0] mem_wr_data;
  logic        mem_busy;
  logic        mem_rd_valid;
  logic [15:0] mem_rd_data;
`ifdef GEO_PIXEL_WRITER_COLLISION_EN
  logic [15:0] collision_count;
`endif

  always #5 clk = ~clk;

  geo_pixel_writer #(.MEM_AW(20)) dut (
    .clk             (clk),
    .reset           (reset),
    .pixel_cmd_rdy   (pixel_cmd_rdy),
    .pixel_cmd       (pixel_cmd),
    .draw_busy       (draw_busy),
    .mem_addr        (mem_addr),
    .mem_rd_req      (mem_rd_req),
    .mem_wr_req      (mem_wr_req),
    .mem_wr_data     (mem_wr_data),
    .mem_busy        (mem_busy),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_data     (mem_rd_data)
`ifdef GEO_PIXEL_WRITER_COLLISION_EN
    ,
    .collision_count (collision_count)
`endif
  );

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  rd_accepts = 0;
  int  base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset && mem_rd_req && !mem_busy) rd_accepts++;
      if (reset && mem_wr_req && !mem_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.addr));
          chk("wr_data", 32'(mem_wr_data), 32'(e.data));
        end
      end
    end
  endtask

  task automatic send(input logic [3:0] cmd, input logic [7:0] col, input logic [3:0] w,
                      input logic [3:0] tb, input logic [19:0] addr);
    pixel_cmd     = {cmd, col, w, tb, addr};
    pixel_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    pixel_cmd_rdy = 1'b0;
    pixel_cmd     = '0;
  endtask

  task automatic serve_read(input logic [15:0] d, input int lat);
    logic got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_rd_req && !mem_busy) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rd_accept_seen", 32'(got), 32'd1);
    if (got) begin
      @(posedge clk); #1;
      repeat (lat) begin @(posedge clk); #1; end
      mem_rd_valid = 1'b1;
      mem_rd_data  = d;
      @(posedge clk); #1;
      mem_rd_valid = 1'b0;
      mem_rd_data  = 16'h0000;
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50; i++) begin
      if (!draw_busy) break;
      @(posedge clk); #1;
    end
    chk(name, 32'(draw_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    pixel_cmd_rdy = 1'b0;
    pixel_cmd     = '0;
    mem_busy      = 1'b0;
    mem_rd_valid  = 1'b0;
    mem_rd_data   = 16'h0000;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(draw_busy), 32'd0);
    chk("rst_rd_req", 32'(mem_rd_req), 32'd0);
    chk("rst_wr_req", 32'(mem_wr_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wr_data", 32'(mem_wr_data), 32'd0);
`ifdef GEO_PIXEL_WRITER_COLLISION_EN
    chk("rst_coll", 32'(collision_count), 32'd0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    // Masked write equal to the mask is skipped entirely.
    send(4'd10, 8'h05, 4'd0, 4'd0, 20'h0);
    chk("mask_set_busy", 32'(draw_busy), 32'd0);
    base = rd_accepts;
    send(4'd2, 8'h05, 4'd3, 4'd0, 20'h00020);
    chk("masked_busy", 32'(draw_busy), 32'd0);
    chk("masked_rd_req", 32'(mem_rd_req), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("masked_no_read", 32'(rd_accepts - base), 32'd0);

    // Masked write with a different colour proceeds: field [3:0] <- 6.
    exp_q.push_back('{addr: 20'h00020, data: 16'h0006});
    send(4'd2, 8'h06, 4'd3, 4'd0, 20'h00020);
    chk("unmasked_busy", 32'(draw_busy), 32'd1);
    serve_read(16'h0000, 2);
    wait_idle("unmasked_idle");

    // 4 bpp RMW at tbit 5: field [7:4] <- A over 0xFFFF.
    exp_q.push_back('{addr: 20'h00010, data: 16'hFFAF});
    send(4'd1, 8'h0A, 4'd3, 4'd5, 20'h00010);
    chk("rmw_busy", 32'(draw_busy), 32'd1);
    chk("rmw_rd_req", 32'(mem_rd_req), 32'd1);
    chk("rmw_addr", 32'(mem_addr), 32'h10);
    serve_read(16'hFFFF, 0);
    wait_idle("rmw_idle");

    // 16 bpp write: no read, one busy cycle.
    exp_q.push_back('{addr: 20'h00040, data: 16'h003C});
    send(4'd1, 8'h3C, 4'd15, 4'd0, 20'h00040);
    chk("w16_busy", 32'(draw_busy), 32'd1);
    chk("w16_wr_req", 32'(mem_wr_req), 32'd1);
    chk("w16_rd_req", 32'(mem_rd_req), 32'd0);
    @(posedge clk); #1;
    chk("w16_busy_after", 32'(draw_busy), 32'd0);

    // Copy bit 9 of 0x0200 then paste it into bit 0.
    send(4'd6, 8'h01, 4'd0, 4'd9, 20'h00030);
    chk("copy_busy", 32'(draw_busy), 32'd1);
    serve_read(16'h0200, 1);
    chk("copy_done", 32'(draw_busy), 32'd0);
    exp_q.push_back('{addr: 20'h00032, data: 16'h0001});
    send(4'd3, 8'h00, 4'd0, 4'd0, 20'h00032);
    serve_read(16'h0000, 0);
    wait_idle("paste_idle");

    // Arbiter stall during RD_REQ: 2 bpp at tbit 2 -> field [3:2] <- 3.
    exp_q.push_back('{addr: 20'h00050, data: 16'h000C});
    mem_busy = 1'b1;
    base = rd_accepts;
    send(4'd1, 8'h03, 4'd1, 4'd2, 20'h00050);
    for (int i = 0; i < 4; i++) begin
      chk("stall_rd_req", 32'(mem_rd_req), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'h50);
      @(posedge clk); #1;
    end
    mem_busy = 1'b0;
    serve_read(16'h0000, 1);
    wait_idle("stall_idle");
    chk("stall_one_read", 32'(rd_accepts - base), 32'd1);

    // Illegal width code drops the command.
    base = rd_accepts;
    send(4'd1, 8'hFF, 4'd2, 4'd0, 20'h00070);
    chk("illegal_busy", 32'(draw_busy), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    chk("illegal_no_read", 32'(rd_accepts - base), 32'd0);

    // Paste mask equal to copy_buf (0x01) skips the paste.
    send(4'd11, 8'h01, 4'd0, 4'd0, 20'h0);
    send(4'd4, 8'h00, 4'd3, 4'd0, 20'h00080);
    chk("pmask_busy", 32'(draw_busy), 32'd0);
    chk("pmask_rd_req", 32'(mem_rd_req), 32'd0);

`ifdef GEO_PIXEL_WRITER_COLLISION_EN
    chk("coll_cleared", 32'(collision_count), 32'd0);
    send(4'd6, 8'h00, 4'd1, 4'd0, 20'h00090);
    serve_read(16'h0003, 0);
    chk("coll_one", 32'(collision_count), 32'd1);
    send(4'd6, 8'h03, 4'd1, 4'd0, 20'h00090);
    serve_read(16'h0003, 0);
    chk("coll_match", 32'(collision_count), 32'd1);
`endif

    // Reset while waiting for read data aborts without a write.
    send(4'd1, 8'h05, 4'd3, 4'd0, 20'h000A0);
    chk("abort_rd_req", 32'(mem_rd_req), 32'd1);
    @(posedge clk); #1;
    chk("abort_in_wait", 32'(draw_busy), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(draw_busy), 32'd0);
    chk("abort_rd_req_low", 32'(mem_rd_req), 32'd0);
    chk("abort_wr_req", 32'(mem_wr_req), 32'd0);
`ifdef GEO_PIXEL_WRITER_COLLISION_EN
    chk("abort_coll", 32'(collision_count), 32'd0);
`endif
    reset = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 16'hFFFF;
    @(posedge clk); #1;
    mem_rd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_stays_idle", 32'(draw_busy), 32'd0);
    chk("abort_no_wr_req", 32'(mem_wr_req), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
